// File: rtl/pl_hazard_ctrl_if.sv
// Pipeline hazard-control signal bundle.
// master: the pipeline datapath, which drives register numbers, write enables and memory status.
// slave:  the hazard unit, which returns stall/flush/forward controls and status.
//
// Memory handshake: MemReqM is high while the memory-stage instruction needs data memory.
// MemReadyM is high in the cycle the access completes.
// An access finishes in the cycle where MemReqM and MemReadyM are both high.
// MemReqM high with MemReadyM low means the memory stage must wait.
// MemReadyM has no meaning while MemReqM is low, except during an outstanding wait.
interface pl_hazard_ctrl_if;
   logic [4:0]  Rs1D;
   logic [4:0]  Rs2D;
   logic [4:0]  Rs1E;
   logic [4:0]  Rs2E;
   logic [4:0]  RdE;
   logic        RegWriteE;
   logic        RegWriteM;
   logic        RegWriteW;
   logic [1:0]  ResultSrcE;
   logic [4:0]  RdM;
   logic [4:0]  RdW;
   logic        PCSrcE;
   logic        MemReqM;
   logic        MemReadyM;
   logic        StallF;
   logic        StallD;
   logic        StallE;
   logic        StallM;
   logic        FlushD;
   logic        FlushE;
   logic        FlushW;
   logic [1:0]  ForwardAE;
   logic [1:0]  ForwardBE;
   logic        MemTimeout;
   logic [15:0] StallCnt;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, RegWriteM, RegWriteW,
             ResultSrcE, RdM, RdW, PCSrcE, MemReqM, MemReadyM,
      input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
             ForwardAE, ForwardBE, MemTimeout, StallCnt
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, RegWriteM, RegWriteW,
             ResultSrcE, RdM, RdW, PCSrcE, MemReqM, MemReadyM,
      output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
             ForwardAE, ForwardBE, MemTimeout, StallCnt
   );
endinterface

// File: rtl/pl_hazard_ctrl.sv
// Pipeline hazard controller: load-use and data-hazard stalls, branch flushes,
// ALU operand forwarding, and a data-memory wait FSM with a sticky timeout.
// Optional feature macro: PL_HAZARD_FWD_EN enables operand forwarding.
// Without PL_HAZARD_FWD_EN, forwarding is off and any pending write to a decode
// source register stalls decode.
// o_dbg_state exposes the FSM state: 0 = RUN, 1 = MEM_WAIT, 2 = TIMEOUT.
module pl_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   pl_hazard_ctrl_if.slave  hz,
   output logic [1:0]       o_dbg_state
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_TIMEOUT  = 2'd2
   } state_t;

   // The last wait-counter value before a timeout is declared.
   localparam logic [15:0] LP_WAIT_LAST = 16'(MEM_TIMEOUT - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_wait_cnt;
   logic [15:0] w_wait_cnt_nxt;
   logic [15:0] r_stall_cnt;
   logic        w_mem_stall;
   logic        w_load_use;
   logic        w_data_hazard;
   logic [1:0]  w_fwd_a;
   logic [1:0]  w_fwd_b;
   logic        w_stall_f;
   logic        w_stall_d;
   logic        w_stall_e;
   logic        w_stall_m;
   logic        w_flush_d;
   logic        w_flush_e;
   logic        w_flush_w;

   // FSM state and wait counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_RUN;
         r_wait_cnt <= 16'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
      end
   end

   // Memory-wait next state.
   // The memory stall is combinational, so it is held in the same cycle the wait starts.
   // It is released in the same cycle MemReadyM arrives.
   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      w_mem_stall    = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (hz.MemReqM && !hz.MemReadyM) begin
               w_state_nxt    = ST_MEM_WAIT;
               w_wait_cnt_nxt = 16'd0;
               w_mem_stall    = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (hz.MemReadyM) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_mem_stall    = 1'b1;
               w_wait_cnt_nxt = r_wait_cnt + 16'd1;
               if (r_wait_cnt == LP_WAIT_LAST) begin
                  w_state_nxt = ST_TIMEOUT;
               end
            end
         end
         ST_TIMEOUT: begin
            // Only reset leaves this state.
            w_mem_stall = 1'b1;
         end
         default: begin
            w_state_nxt    = ST_RUN;
            w_wait_cnt_nxt = 16'd0;
         end
      endcase
   end

   // Load in execute whose destination register is read by decode.
   always_comb begin
      w_load_use = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                   ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
   end

`ifdef PL_HAZARD_FWD_EN
   // The memory stage wins over writeback because it holds the younger result.
   // Only a load still needs a bubble.
   logic w_unused_fwd;

   always_comb begin
      w_data_hazard = w_load_use;
      w_fwd_a       = 2'b00;
      w_fwd_b       = 2'b00;
      if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs1E)) begin
         w_fwd_a = 2'b10;
      end else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs1E)) begin
         w_fwd_a = 2'b01;
      end
      if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs2E)) begin
         w_fwd_b = 2'b10;
      end else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs2E)) begin
         w_fwd_b = 2'b01;
      end
   end

   assign w_unused_fwd = hz.RegWriteE;
`else
   // Without forwarding, decode waits until every writer of its sources has left the memory stage.
   logic w_busy_rs1;
   logic w_busy_rs2;
   logic w_unused_fwd;

   always_comb begin
      w_busy_rs1 = (hz.Rs1D != 5'd0) &&
                   ((hz.RegWriteE && (hz.Rs1D == hz.RdE)) ||
                    (hz.RegWriteM && (hz.Rs1D == hz.RdM)));
      w_busy_rs2 = (hz.Rs2D != 5'd0) &&
                   ((hz.RegWriteE && (hz.Rs2D == hz.RdE)) ||
                    (hz.RegWriteM && (hz.Rs2D == hz.RdM)));
      w_data_hazard = w_load_use || w_busy_rs1 || w_busy_rs2;
      w_fwd_a       = 2'b00;
      w_fwd_b       = 2'b00;
   end

   assign w_unused_fwd = ^{hz.Rs1E, hz.Rs2E, hz.RegWriteW, hz.RdW};
`endif

   // Control priority, highest first: reset, memory stall, taken branch, data hazard.
   always_comb begin
      w_stall_f = 1'b0;
      w_stall_d = 1'b0;
      w_stall_e = 1'b0;
      w_stall_m = 1'b0;
      w_flush_d = 1'b0;
      w_flush_e = 1'b0;
      w_flush_w = 1'b0;
      if (!rst_n) begin
         // All controls are quiet while reset is held.
      end else if (w_mem_stall) begin
         w_stall_f = 1'b1;
         w_stall_d = 1'b1;
         w_stall_e = 1'b1;
         w_stall_m = 1'b1;
         w_flush_w = 1'b1;
      end else if (hz.PCSrcE) begin
         // Stalling would keep the wrong-path instruction, so the branch wins.
         w_flush_d = 1'b1;
         w_flush_e = 1'b1;
      end else if (w_data_hazard) begin
         w_stall_f = 1'b1;
         w_stall_d = 1'b1;
         w_flush_e = 1'b1;
      end
   end

   // Saturating count of fetch-stall cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= 16'd0;
      end else if (w_stall_f && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign hz.StallF     = w_stall_f;
   assign hz.StallD     = w_stall_d;
   assign hz.StallE     = w_stall_e;
   assign hz.StallM     = w_stall_m;
   assign hz.FlushD     = w_flush_d;
   assign hz.FlushE     = w_flush_e;
   assign hz.FlushW     = w_flush_w;
   assign hz.ForwardAE  = w_fwd_a;
   assign hz.ForwardBE  = w_fwd_b;
   assign hz.MemTimeout = (r_state == ST_TIMEOUT);
   assign hz.StallCnt   = r_stall_cnt;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// Directed bench for pl_hazard_ctrl, built with MEM_TIMEOUT = 8.
// The ctl vector is {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}.
module tb_pl_hazard_ctrl;
   logic       clk;
   logic       rst_n;
   logic [1:0] dbg_state;
   logic [6:0] ctl;
   int         checks;
   int         failures;

   pl_hazard_ctrl_if hif ();

   pl_hazard_ctrl #(.MEM_TIMEOUT(8)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .hz          (hif.slave),
      .o_dbg_state (dbg_state)
   );

   assign ctl = {hif.StallF, hif.StallD, hif.StallE, hif.StallM,
                 hif.FlushD, hif.FlushE, hif.FlushW};

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task set_idle();
      hif.Rs1D = 5'd0; hif.Rs2D = 5'd0; hif.Rs1E = 5'd0; hif.Rs2E = 5'd0;
      hif.RdE = 5'd0; hif.RdM = 5'd0; hif.RdW = 5'd0;
      hif.RegWriteE = 1'b0; hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
      hif.ResultSrcE = 2'b00; hif.PCSrcE = 1'b0;
      hif.MemReqM = 1'b0; hif.MemReadyM = 1'b0;
   endtask

   // Advance to one time unit past the next rising edge.
   task tick();
      @(posedge clk);
      #1;
   endtask

   task do_reset();
      set_idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task test_reset();
      rst_n = 1'b0;
      set_idle();
      hif.MemReqM = 1'b1; hif.PCSrcE = 1'b1;
      hif.ResultSrcE = 2'b01; hif.RdE = 5'd5; hif.Rs1D = 5'd5;
      #1;
      checks++;
      if (ctl !== 7'b0000000) begin
         failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 7'b0000000);
      end
      tick();
      checks++;
      if ({dbg_state, hif.MemTimeout, hif.StallCnt} !== {2'd0, 1'b0, 16'd0}) begin
         failures++;
         $display("FAIL reset_state got state=%0d to=%b cnt=%0d exp 0/0/0",
                  dbg_state, hif.MemTimeout, hif.StallCnt);
      end
      set_idle();
      rst_n = 1'b1;
      #1;
      checks++;
      if (ctl !== 7'b0000000) begin
         failures++; $display("FAIL reset_release_ctl got=%b exp=%b", ctl, 7'b0000000);
      end
   endtask

   task test_load_use();
      do_reset();
      hif.RdE = 5'd5; hif.ResultSrcE = 2'b01; hif.RegWriteE = 1'b1; hif.Rs1D = 5'd5;
      #1;
      checks++;
      if (ctl !== 7'b1100010) begin
         failures++; $display("FAIL load_use_rs1 got=%b exp=%b", ctl, 7'b1100010);
      end
      tick();
      set_idle();
      #1;
      checks++;
      if ({ctl, hif.StallCnt} !== {7'b0000000, 16'd1}) begin
         failures++; $display("FAIL load_use_one_cycle got ctl=%b cnt=%0d exp ctl=0000000 cnt=1", ctl, hif.StallCnt);
      end
      hif.RdE = 5'd9; hif.ResultSrcE = 2'b01; hif.RegWriteE = 1'b1; hif.Rs1D = 5'd2; hif.Rs2D = 5'd9;
      #1;
      checks++;
      if (ctl !== 7'b1100010) begin
         failures++; $display("FAIL load_use_rs2 got=%b exp=%b", ctl, 7'b1100010);
      end
      hif.RdE = 5'd0; hif.Rs1D = 5'd0; hif.Rs2D = 5'd0;
      #1;
      checks++;
      if (ctl !== 7'b0000000) begin
         failures++; $display("FAIL load_use_x0 got=%b exp=%b", ctl, 7'b0000000);
      end
      hif.RdE = 5'd6; hif.Rs1D = 5'd5; hif.Rs2D = 5'd7;
      #1;
      checks++;
      if (ctl !== 7'b0000000) begin
         failures++; $display("FAIL load_no_match got=%b exp=%b", ctl, 7'b0000000);
      end
      // ALU writer in execute: bypassed with forwarding, stalls without it
      hif.ResultSrcE = 2'b00; hif.RdE = 5'd5;
      #1;
      checks++;
`ifdef PL_HAZARD_FWD_EN
      if (ctl !== 7'b0000000) begin
         failures++; $display("FAIL alu_dep_e got=%b exp=%b", ctl, 7'b0000000);
      end
`else
      if (ctl !== 7'b1100010) begin
         failures++; $display("FAIL alu_dep_e got=%b exp=%b", ctl, 7'b1100010);
      end
`endif
      set_idle();
   endtask

   task test_forward();
      logic [3:0] exp_fwd [4];
`ifdef PL_HAZARD_FWD_EN
      exp_fwd[0] = 4'b1010; exp_fwd[1] = 4'b0101; exp_fwd[2] = 4'b0110; exp_fwd[3] = 4'b0000;
`else
      exp_fwd[0] = 4'b0000; exp_fwd[1] = 4'b0000; exp_fwd[2] = 4'b0000; exp_fwd[3] = 4'b0000;
`endif
      do_reset();
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: begin hif.RegWriteM = 1'b1; hif.RdM = 5'd3; hif.RegWriteW = 1'b1; hif.RdW = 5'd3;
                     hif.Rs1E = 5'd3; hif.Rs2E = 5'd3; end
            1: begin hif.RdM = 5'd0; end
            2: begin hif.RdM = 5'd3; hif.RdW = 5'd4; hif.Rs1E = 5'd4; hif.Rs2E = 5'd3; end
            default: begin hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0; end
         endcase
         #1;
         checks++;
         if ({hif.ForwardAE, hif.ForwardBE} !== exp_fwd[i]) begin
            failures++;
            $display("FAIL forward_%0d got AE=%b BE=%b exp AE=%b BE=%b", i,
                     hif.ForwardAE, hif.ForwardBE, exp_fwd[i][3:2], exp_fwd[i][1:0]);
         end
      end
      set_idle();
   endtask

   task test_mem_stall();
      logic [1:0] exp_ae;
`ifdef PL_HAZARD_FWD_EN
      exp_ae = 2'b10;
`else
      exp_ae = 2'b00;
`endif
      do_reset();
      hif.MemReqM = 1'b1; hif.MemReadyM = 1'b0;
      hif.RegWriteM = 1'b1; hif.RdM = 5'd3; hif.Rs1E = 5'd3;
      for (int c = 0; c < 4; c++) begin
         // branch and load-use overlap the second wait cycle; the memory stall must dominate
         hif.PCSrcE = (c == 1);
         hif.ResultSrcE = (c == 1) ? 2'b01 : 2'b00;
         hif.RdE = (c == 1) ? 5'd5 : 5'd0;
         hif.Rs1D = (c == 1) ? 5'd5 : 5'd0;
         #1;
         checks++;
         if ({ctl, dbg_state, hif.ForwardAE} !== {7'b1111001, (c == 0) ? 2'd0 : 2'd1, exp_ae}) begin
            failures++;
            $display("FAIL mem_stall_c%0d got ctl=%b st=%0d AE=%b exp ctl=1111001 st=%0d AE=%b",
                     c, ctl, dbg_state, hif.ForwardAE, (c == 0) ? 0 : 1, exp_ae);
         end
         tick();
      end
      set_idle();
      hif.MemReqM = 1'b1; hif.MemReadyM = 1'b1;
      #1;
      checks++;
      if (ctl !== 7'b0000000) begin
         failures++; $display("FAIL mem_ready_release got=%b exp=%b", ctl, 7'b0000000);
      end
      tick();
      set_idle();
      checks++;
      if ({dbg_state, hif.StallCnt} !== {2'd0, 16'd4}) begin
         failures++; $display("FAIL mem_stall_done got st=%0d cnt=%0d exp st=0 cnt=4", dbg_state, hif.StallCnt);
      end
   endtask

   task test_timeout();
      do_reset();
      hif.MemReqM = 1'b1; hif.MemReadyM = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         checks++;
         if ({dbg_state, hif.MemTimeout} !== {2'd1, 1'b0}) begin
            failures++; $display("FAIL timeout_wait_%0d got st=%0d to=%b exp st=1 to=0", i, dbg_state, hif.MemTimeout);
         end
         tick();
      end
      checks++;
      if ({dbg_state, hif.MemTimeout, hif.StallCnt} !== {2'd2, 1'b1, 16'd9}) begin
         failures++;
         $display("FAIL timeout_hit got st=%0d to=%b cnt=%0d exp st=2 to=1 cnt=9", dbg_state, hif.MemTimeout, hif.StallCnt);
      end
      hif.MemReqM = 1'b0; hif.MemReadyM = 1'b1;
      #1;
      checks++;
      if (ctl !== 7'b1111001) begin
         failures++; $display("FAIL timeout_sticky_ctl got=%b exp=%b", ctl, 7'b1111001);
      end
      tick();
      tick();
      checks++;
      if ({hif.MemTimeout, hif.StallCnt} !== {1'b1, 16'd11}) begin
         failures++; $display("FAIL timeout_sticky got to=%b cnt=%0d exp to=1 cnt=11", hif.MemTimeout, hif.StallCnt);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ctl, dbg_state, hif.MemTimeout, hif.StallCnt} !== {7'b0000000, 2'd0, 1'b0, 16'd0}) begin
         failures++;
         $display("FAIL timeout_async_reset got ctl=%b st=%0d to=%b cnt=%0d exp all zero",
                  ctl, dbg_state, hif.MemTimeout, hif.StallCnt);
      end
      tick();
      rst_n = 1'b1;
      set_idle();
      tick();
      checks++;
      if ({ctl, dbg_state, hif.StallCnt} !== {7'b0000000, 2'd0, 16'd0}) begin
         failures++;
         $display("FAIL timeout_release got ctl=%b st=%0d cnt=%0d exp ctl=0000000 st=0 cnt=0", ctl, dbg_state, hif.StallCnt);
      end
   endtask

   task test_branch();
      do_reset();
      hif.RdE = 5'd5; hif.ResultSrcE = 2'b01; hif.RegWriteE = 1'b1; hif.Rs1D = 5'd5; hif.PCSrcE = 1'b1;
      #1;
      checks++;
      if (ctl !== 7'b0000110) begin
         failures++; $display("FAIL branch_over_load got=%b exp=%b", ctl, 7'b0000110);
      end
      tick();
      checks++;
      if (hif.StallCnt !== 16'd0) begin
         failures++; $display("FAIL branch_no_count got=%0d exp=0", hif.StallCnt);
      end
      set_idle();
      hif.RegWriteM = 1'b1; hif.RdM = 5'd7; hif.Rs2D = 5'd7; hif.Rs2E = 5'd7;
      #1;
      checks++;
`ifdef PL_HAZARD_FWD_EN
      if ({ctl, hif.ForwardBE} !== {7'b0000000, 2'b10}) begin
         failures++; $display("FAIL mem_dep got ctl=%b BE=%b exp ctl=0000000 BE=10", ctl, hif.ForwardBE);
      end
`else
      if ({ctl, hif.ForwardBE} !== {7'b1100010, 2'b00}) begin
         failures++; $display("FAIL mem_dep got ctl=%b BE=%b exp ctl=1100010 BE=00", ctl, hif.ForwardBE);
      end
`endif
      // writer moves on to writeback: decode is free in both builds
      tick();
      hif.RegWriteM = 1'b0; hif.RdM = 5'd0; hif.RegWriteW = 1'b1; hif.RdW = 5'd7;
      #1;
      checks++;
      if (ctl !== 7'b0000000) begin
         failures++; $display("FAIL mem_dep_cleared got=%b exp=%b", ctl, 7'b0000000);
      end
      set_idle();
   endtask

   task test_back_to_back();
      do_reset();
      hif.RdE = 5'd4; hif.ResultSrcE = 2'b01; hif.Rs2D = 5'd4;
      tick();
      set_idle();
      hif.MemReqM = 1'b1; hif.MemReadyM = 1'b0;
      #1;
      checks++;
      if (ctl !== 7'b1111001) begin
         failures++; $display("FAIL b2b_mem got=%b exp=%b", ctl, 7'b1111001);
      end
      tick();
      hif.MemReadyM = 1'b1;
      tick();
      set_idle();
      checks++;
      if ({dbg_state, hif.StallCnt} !== {2'd0, 16'd2}) begin
         failures++; $display("FAIL b2b_count got st=%0d cnt=%0d exp st=0 cnt=2", dbg_state, hif.StallCnt);
      end
   endtask

   task test_saturation();
      do_reset();
      hif.MemReqM = 1'b1; hif.MemReadyM = 1'b0;
      repeat (65540) @(posedge clk);
      #1;
      checks++;
      if (hif.StallCnt !== 16'hFFFF) begin
         failures++; $display("FAIL stallcnt_saturate got=%h exp=ffff", hif.StallCnt);
      end
      do_reset();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      set_idle();
      test_reset();
      test_load_use();
      test_forward();
      test_mem_stall();
      test_timeout();
      test_branch();
      test_back_to_back();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pl_hazard_ctrl.md
PL_HAZARD_CTRL -- requirements
Module: pl_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum data-memory wait cycles before a timeout is declared (range 1..65535).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 Rs1D, Rs2D  input  5 each  source register numbers in decode.
REQ-005 Rs1E, Rs2E, RdE  input  5 each  source and destination register numbers in execute.
REQ-006 RegWriteE, RegWriteM, RegWriteW  input  1 each  register-write enable per stage.
REQ-007 ResultSrcE  input  2  result select in execute; 2'b01 marks a load.
REQ-008 RdM, RdW  input  5 each  destination register numbers in memory and writeback.
REQ-009 PCSrcE  input  1  branch or jump taken in execute.
REQ-010 MemReqM, MemReadyM  input  1 each  data-memory access request and completion.
REQ-011 StallF, StallD, StallE, StallM  output  1 each  hold the pipeline register feeding that stage.
REQ-012 FlushD, FlushE, FlushW  output  1 each  clear the pipeline register feeding that stage to a bubble.
REQ-013 ForwardAE, ForwardBE  output  2 each  ALU operand select: 00 register file, 01 writeback result, 10 memory ALU result.
REQ-014 MemTimeout  output  1  sticky memory-timeout flag.
REQ-015 StallCnt  output  16  saturating count of stalled cycles.

Function
REQ-016 The FSM SHALL have three states: RUN, MEM_WAIT and TIMEOUT.
REQ-017 In RUN, MemReqM=1 with MemReadyM=0 SHALL move the FSM to MEM_WAIT, clear the wait counter, and assert all four Stall outputs and FlushW in the same cycle (combinational).
REQ-018 In MEM_WAIT, all four Stall outputs and FlushW SHALL stay asserted and the wait counter SHALL increment each cycle.
REQ-019 In MEM_WAIT, MemReadyM=1 SHALL return the FSM to RUN and deassert the memory stall in that same cycle.
REQ-020 In MEM_WAIT, if the wait counter equals MEM_TIMEOUT-1 and MemReadyM=0, the FSM SHALL go to TIMEOUT.
REQ-021 In TIMEOUT, MemTimeout SHALL be 1 and all Stall outputs and FlushW SHALL stay 1 until reset; there is no other exit.
REQ-022 A load-use hazard SHALL be detected when ResultSrcE=01, RdE!=0 and RdE equals Rs1D or Rs2D.
REQ-023 A load-use hazard SHALL assert StallF, StallD and FlushE for one cycle.
REQ-024 PCSrcE=1 SHALL assert FlushD and FlushE.
REQ-025 When PCSrcE=1 and a load-use hazard occur together, PCSrcE SHALL win: StallF=StallD=0, FlushD=FlushE=1.
REQ-026 A memory stall (REQ-017..021) SHALL take priority over all other conditions: FlushD=FlushE=0 and ForwardAE/BE keep their combinational values.
REQ-027 ForwardAE SHALL be 10 if RegWriteM=1, RdM!=0 and RdM=Rs1E.
REQ-028 Otherwise ForwardAE SHALL be 01 if RegWriteW=1, RdW!=0 and RdW=Rs1E; otherwise 00.
REQ-029 ForwardBE SHALL follow the same rules as ForwardAE using Rs2E.
REQ-030 StallCnt SHALL increment on every cycle in which StallF=1, and SHALL saturate at 16'hFFFF.

Reset
REQ-031 rst_n=0 SHALL immediately force: FSM to RUN, wait counter 0, StallCnt 0, MemTimeout 0.
REQ-032 While rst_n=0, all Stall and Flush outputs SHALL be 0.
REQ-033 Reset asserted during MEM_WAIT or TIMEOUT SHALL abandon the access with no residual stall after release.

Configuration
REQ-034 With macro PL_HAZARD_FWD_EN defined, forwarding SHALL operate per REQ-027..029.
REQ-035 Without PL_HAZARD_FWD_EN, ForwardAE and ForwardBE SHALL be constant 00.
REQ-036 Without PL_HAZARD_FWD_EN, any decode source register (nonzero) matching RdE with RegWriteE=1, or RdM with RegWriteM=1, SHALL assert StallF, StallD and FlushE until the writer leaves the memory stage.

Verification
REQ-037 RdE=5, ResultSrcE=01, Rs1D=5 -> StallF=StallD=FlushE=1 for exactly 1 cycle; StallCnt +1.
REQ-038 RegWriteM=1, RdM=3, RegWriteW=1, RdW=3, Rs1E=3 -> ForwardAE=10; with RdM=0 -> ForwardAE=01.
REQ-039 MemReqM=1, MemReadyM=0 for 4 cycles, then 1 -> all stalls high for 4 cycles, FSM back in RUN on the 5th cycle, StallCnt=4.
REQ-040 MEM_TIMEOUT=8, MemReadyM held 0 -> MemTimeout=1 after 8 wait cycles and stays 1; rst_n pulse clears it and releases all stalls.
REQ-041 PCSrcE=1 during a load-use condition -> FlushD=FlushE=1, StallF=0; repeat without PL_HAZARD_FWD_EN with RdM=Rs2D -> stall asserted, ForwardBE=00.
